// File: rtl/pwm_capture_pkg.sv
// ============================================================================
// pwm_capture_pkg : register map, status/ctrl bit indices and FSM states
// Revision 1.0
// ============================================================================
`default_nettype none

package pwm_capture_pkg;

    typedef logic [1:0] reg_addr_t;

    localparam reg_addr_t ADDR_WIDTH  = 2'd0;
    localparam reg_addr_t ADDR_PERIOD = 2'd1;
    localparam reg_addr_t ADDR_STATUS = 2'd2;
    localparam reg_addr_t ADDR_CTRL   = 2'd3;

    localparam int ST_VALID    = 0;
    localparam int ST_NEW      = 1;
    localparam int ST_TIMEOUT  = 2;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        LOW  = 2'b10
    } state_e;

endpackage

`default_nettype wire

// File: rtl/pwm_capture_if.sv
// ============================================================================
// pwm_capture_if : Avalon-MM slave bus bundle for the PWM capture block
// Revision 1.0
// ============================================================================
`default_nettype none

interface pwm_capture_if;
    import pwm_capture_pkg::*;

    reg_addr_t   avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );

endinterface

`default_nettype wire

// File: rtl/pwm_capture_sync_edge_detect.sv
// ============================================================================
// sync_edge_detect : multi-flop synchronizer with single-cycle rise/fall pulses
// Revision 1.0
// ============================================================================
`default_nettype none

module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_stages
            $error("sync_edge_detect: SYNC_STAGES must be at least 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SYNC_STAGES:0]   prime_q;

    // prime_q walks a 1 through the chain so that no edge is reported until
    // prev_q holds a real sample; a pin already high at reset release is not a rise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            prime_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q  <= sync_q[SYNC_STAGES-1];
            prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign rise_o = prime_q[SYNC_STAGES] &  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = prime_q[SYNC_STAGES] & ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

`default_nettype wire

// File: rtl/pwm_capture.sv
// ============================================================================
// pwm_capture : measures high-time and period of a PWM input, Avalon-MM slave
// Revision 1.0
// ============================================================================
`default_nettype none

module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int TIMEOUT_CYC = 2500000,
    parameter int SYNC_STAGES = 2
) (
    input  logic         iCLK,
    input  logic         iRST_N,
    input  logic         pwm_in,
    pwm_capture_if.slave avs,
    output logic         irq
);

    generate
        if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
            $error("pwm_capture: CNT_W must be in 1..32");
        end
        if (TIMEOUT_CYC < 1 || longint'(TIMEOUT_CYC) >= (longint'(1) << CNT_W)) begin : g_bad_timeout
            $error("pwm_capture: TIMEOUT_CYC must be in 1..2^CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    logic rise;
    logic fall;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (iCLK),
        .rst_ni (iRST_N),
        .d_i    (pwm_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    state_e           state_q;
    logic [CNT_W-1:0] cnt_period_q, cnt_high_q, hi_cap_q, tcnt_q;
    logic [CNT_W-1:0] width_q, period_q;
    logic             valid_q, new_q, timeout_q, enable_q, irq_en_q, irq_q;
    logic             valid_d, new_d, timeout_d, enable_d, irq_en_d, irq_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [31:0]      status_w;
    logic             publish;
    logic             tmo_hit;
    logic             unused_wdata;

    // A rise always restarts the silence window, so it beats a coincident timeout.
    assign publish = enable_q && (state_q == LOW) && rise;
    assign tmo_hit = enable_q && !rise && (tcnt_q == TIMEOUT_VAL);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q      <= IDLE;
            cnt_period_q <= '0;
            cnt_high_q   <= '0;
            hi_cap_q     <= '0;
            tcnt_q       <= '0;
            width_q      <= '0;
            period_q     <= '0;
        end else if (!enable_q) begin
            state_q      <= IDLE;
            cnt_period_q <= '0;
            cnt_high_q   <= '0;
            tcnt_q       <= '0;
        end else begin
            tcnt_q <= (rise || tmo_hit) ? ONE : tcnt_q + ONE;
            if (tmo_hit) begin
                state_q      <= IDLE;
                cnt_period_q <= '0;
                cnt_high_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            cnt_period_q <= ONE;
                            cnt_high_q   <= ONE;
                            state_q      <= HIGH;
                        end
                    end
                    HIGH: begin
                        cnt_period_q <= cnt_period_q + ONE;
                        cnt_high_q   <= cnt_high_q + ONE;
                        if (fall) begin
                            hi_cap_q <= cnt_high_q;
                            state_q  <= LOW;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            width_q      <= hi_cap_q;
                            period_q     <= cnt_period_q;
                            cnt_period_q <= ONE;
                            cnt_high_q   <= ONE;
                            state_q      <= HIGH;
                        end else begin
                            cnt_period_q <= cnt_period_q + ONE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        status_w               = '0;
        status_w[ST_VALID]     = valid_q;
        status_w[ST_NEW]       = new_q;
        status_w[ST_TIMEOUT]   = timeout_q;
    end

    always_comb begin
        valid_d   = valid_q;
        new_d     = new_q;
        timeout_d = timeout_q;
        enable_d  = enable_q;
        irq_en_d  = irq_en_q;
        rdata_d   = rdata_q;

        // Read mux uses the _q values, so a same-cycle write is not visible yet.
        if (avs.avs_read) begin
            case (avs.avs_address)
                ADDR_WIDTH:  rdata_d = 32'(width_q);
                ADDR_PERIOD: rdata_d = 32'(period_q);
                ADDR_STATUS: rdata_d = status_w;
                ADDR_CTRL:   rdata_d = {30'd0, irq_en_q, enable_q};
                default:     rdata_d = '0;
            endcase
        end

        if (avs.avs_write) begin
            case (avs.avs_address)
                ADDR_STATUS: begin
                    if (avs.avs_writedata[ST_NEW])     new_d     = 1'b0;
                    if (avs.avs_writedata[ST_TIMEOUT]) timeout_d = 1'b0;
                end
                ADDR_CTRL: begin
                    enable_d = avs.avs_writedata[CTRL_ENABLE];
                    irq_en_d = avs.avs_writedata[CTRL_IRQ_EN];
                end
                default: ;
            endcase
        end

        // Hardware events are applied last so they win over a W1C.
        if (publish) begin
            new_d     = 1'b1;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
        end
        if (tmo_hit) begin
            timeout_d = 1'b1;
            valid_d   = 1'b0;
        end

        irq_d = irq_en_q & (new_q | timeout_q);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            valid_q   <= 1'b0;
            new_q     <= 1'b0;
            timeout_q <= 1'b0;
            enable_q  <= 1'b1;
            irq_en_q  <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            new_q     <= new_d;
            timeout_q <= timeout_d;
            enable_q  <= enable_d;
            irq_en_q  <= irq_en_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign avs.avs_readdata = rdata_q;
    assign irq              = irq_q;
    assign unused_wdata     = ^avs.avs_writedata[31:3];

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// ============================================================================
// tb_pwm_capture : directed, table-driven self-checking bench for pwm_capture
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pwm_capture;
    import pwm_capture_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        pin   = 1'b0;
    logic        irq;
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          t0, t1, t2;
    logic [31:0] d;
    vec_t        tbl [15];

    pwm_capture_if bus ();

    pwm_capture #(
        .CNT_W       (24),
        .TIMEOUT_CYC (1000),
        .SYNC_STAGES (2)
    ) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .pwm_in (pin),
        .avs    (bus.slave),
        .irq    (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Bus access whose sampling clock edge is edge number e.
    task automatic bus_at(input int e, input logic rd, input logic wr, input logic [1:0] a,
                          input logic [31:0] wd, output logic [31:0] q);
        @(negedge clk);
        if (cyc > e - 1) begin
            n_chk++;
            n_fail++;
            $display("FAIL sched: access for edge %0d issued late at %0d", e, cyc);
        end
        while (cyc < e - 1) @(negedge clk);
        bus.avs_address   = a;
        bus.avs_read      = rd;
        bus.avs_write     = wr;
        bus.avs_writedata = wd;
        @(posedge clk);
        #1;
        q                 = bus.avs_readdata;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
    endtask

    task automatic rd_at(input int e, input logic [1:0] a, output logic [31:0] q);
        bus_at(e, 1'b1, 1'b0, a, 32'd0, q);
    endtask

    task automatic wr_at(input int e, input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] dummy;
        bus_at(e, 1'b0, 1'b1, a, wd, dummy);
    endtask

    // Called on a negedge; each period starts with a rising pin edge.
    task automatic train(input int h, input int l, input int n);
        for (int k = 0; k < n; k++) begin
            pin = 1'b1;
            repeat (h) @(negedge clk);
            pin = 1'b0;
            repeat (l) @(negedge clk);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        logic [31:0] q;
        for (int i = lo; i <= hi; i++) begin
            if (tbl[i].wr) begin
                wr_at(cyc + 2, tbl[i].addr, tbl[i].wdata);
            end else begin
                rd_at(cyc + 2, tbl[i].addr, q);
                chk($sformatf("vec%0d_addr%0d", i, tbl[i].addr), q, tbl[i].exp);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{wr: 1'b0, addr: ADDR_WIDTH,  wdata: 32'h0,         exp: 32'h0};
        tbl[1]  = '{wr: 1'b0, addr: ADDR_PERIOD, wdata: 32'h0,         exp: 32'h0};
        tbl[2]  = '{wr: 1'b0, addr: ADDR_STATUS, wdata: 32'h0,         exp: 32'h0};
        tbl[3]  = '{wr: 1'b0, addr: ADDR_CTRL,   wdata: 32'h0,         exp: 32'h1};
        tbl[4]  = '{wr: 1'b0, addr: ADDR_WIDTH,  wdata: 32'h0,         exp: 32'd100};
        tbl[5]  = '{wr: 1'b1, addr: ADDR_WIDTH,  wdata: 32'hFFFF_FFFF, exp: 32'h0};
        tbl[6]  = '{wr: 1'b0, addr: ADDR_WIDTH,  wdata: 32'h0,         exp: 32'd100};
        tbl[7]  = '{wr: 1'b1, addr: ADDR_PERIOD, wdata: 32'h0,         exp: 32'h0};
        tbl[8]  = '{wr: 1'b0, addr: ADDR_PERIOD, wdata: 32'h0,         exp: 32'd500};
        tbl[9]  = '{wr: 1'b1, addr: ADDR_STATUS, wdata: 32'hFFFF_FFFF, exp: 32'h0};
        tbl[10] = '{wr: 1'b0, addr: ADDR_STATUS, wdata: 32'h0,         exp: 32'h1};
        tbl[11] = '{wr: 1'b1, addr: ADDR_CTRL,   wdata: 32'hFFFF_FFFF, exp: 32'h0};
        tbl[12] = '{wr: 1'b0, addr: ADDR_CTRL,   wdata: 32'h0,         exp: 32'h3};
        tbl[13] = '{wr: 1'b1, addr: ADDR_CTRL,   wdata: 32'h1,         exp: 32'h0};
        tbl[14] = '{wr: 1'b0, addr: ADDR_CTRL,   wdata: 32'h0,         exp: 32'h1};

        bus.avs_address   = '0;
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_readdata", bus.avs_readdata, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        rst_n = 1'b1;
        run_vecs(0, 3);
        chk("rst_irq_after", {31'd0, irq}, 32'h0);

        // 75 high / 925 low, three periods; rise-detect edge is pin edge + 3
        @(negedge clk);
        t0 = cyc;
        fork
            train(75, 925, 3);
            begin
                rd_at(t0 + 5, ADDR_PERIOD, d);     chk("first_rise_no_publish", d, 32'h0);
                rd_at(t0 + 1004, ADDR_WIDTH, d);   chk("p2_width", d, 32'd75);
                rd_at(t0 + 1005, ADDR_PERIOD, d);  chk("p2_period", d, 32'd1000);
                rd_at(t0 + 1006, ADDR_STATUS, d);  chk("p2_status", d, 32'h3);
                wr_at(t0 + 2003, ADDR_STATUS, 32'h2);
                rd_at(t0 + 2004, ADDR_STATUS, d);  chk("set_beats_w1c", d, 32'h3);
                rd_at(t0 + 2005, ADDR_WIDTH, d);   chk("p3_width", d, 32'd75);
                rd_at(t0 + 2006, ADDR_PERIOD, d);  chk("p3_period", d, 32'd1000);
                wr_at(t0 + 2008, ADDR_STATUS, 32'h2);
                rd_at(t0 + 2010, ADDR_STATUS, d);  chk("w1c_new", d, 32'h1);
                wr_at(t0 + 2013, ADDR_CTRL, 32'h3);
                rd_at(t0 + 2015, ADDR_CTRL, d);    chk("ctrl_irq_en", d, 32'h3);
            end
        join

        // Stuck low after the train: timeout exactly 1000 cycles after last rise-detect
        rd_at(t0 + 3003, ADDR_STATUS, d);  chk("tmo_not_yet", d, 32'h1);
        chk("irq_not_yet", {31'd0, irq}, 32'h0);
        rd_at(t0 + 3004, ADDR_STATUS, d);  chk("tmo_low_status", d, 32'h4);
        chk("irq_after_tmo", {31'd0, irq}, 32'h1);
        rd_at(t0 + 3006, ADDR_WIDTH, d);   chk("tmo_width_kept", d, 32'd75);
        rd_at(t0 + 3007, ADDR_PERIOD, d);  chk("tmo_period_kept", d, 32'd1000);
        wr_at(t0 + 3010, ADDR_STATUS, 32'h4);
        rd_at(t0 + 3012, ADDR_STATUS, d);  chk("w1c_timeout", d, 32'h0);

        // Stuck high 1500 cycles, then a 100/400 train
        @(negedge clk);
        t1 = cyc;
        fork
            begin
                pin = 1'b1;
                repeat (1500) @(negedge clk);
                pin = 1'b0;
                repeat (400) @(negedge clk);
                train(100, 400, 2);
            end
            begin
                rd_at(t1 + 1003, ADDR_STATUS, d);  chk("hi_tmo_not_yet", d, 32'h0);
                chk("hi_irq_not_yet", {31'd0, irq}, 32'h0);
                rd_at(t1 + 1004, ADDR_STATUS, d);  chk("hi_tmo_status", d, 32'h4);
                chk("hi_irq", {31'd0, irq}, 32'h1);
                rd_at(t1 + 1905, ADDR_PERIOD, d);  chk("resume_no_publish", d, 32'd1000);
                rd_at(t1 + 2403, ADDR_STATUS, d);  chk("resume_pre_status", d, 32'h4);
                rd_at(t1 + 2404, ADDR_WIDTH, d);   chk("resume_width", d, 32'd100);
                rd_at(t1 + 2405, ADDR_PERIOD, d);  chk("resume_period", d, 32'd500);
                rd_at(t1 + 2406, ADDR_STATUS, d);  chk("resume_status", d, 32'h3);
            end
        join

        // Asynchronous reset in the middle of a high phase
        @(negedge clk);
        t2 = cyc;
        fork
            train(100, 400, 5);
            begin
                rd_at(t2 + 505, ADDR_WIDTH, d);    chk("pre_rst_width", d, 32'd100);
                chk("pre_rst_irq", {31'd0, irq}, 32'h1);
                while (cyc < t2 + 1049) @(negedge clk);
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                chk("async_rst_readdata", bus.avs_readdata, 32'h0);
                chk("async_rst_irq", {31'd0, irq}, 32'h0);
                @(negedge clk);
                rst_n = 1'b1;
                rd_at(t2 + 1060, ADDR_CTRL, d);    chk("post_rst_ctrl", d, 32'h1);
                rd_at(t2 + 1061, ADDR_STATUS, d);  chk("post_rst_status", d, 32'h0);
                rd_at(t2 + 1505, ADDR_PERIOD, d);  chk("post_rst_first_rise", d, 32'h0);
                rd_at(t2 + 2003, ADDR_STATUS, d);  chk("post_rst_pre_pub", d, 32'h0);
                rd_at(t2 + 2004, ADDR_WIDTH, d);   chk("post_rst_width", d, 32'd100);
                rd_at(t2 + 2005, ADDR_PERIOD, d);  chk("post_rst_period", d, 32'd500);
                rd_at(t2 + 2006, ADDR_STATUS, d);  chk("post_rst_status2", d, 32'h3);
                chk("post_rst_irq_off", {31'd0, irq}, 32'h0);
            end
        join

        // Register access table: RO writes ignored, reserved bits zero, CTRL RW
        run_vecs(4, 14);

        // Read and write CTRL in the same cycle returns the pre-write value
        bus_at(cyc + 2, 1'b1, 1'b1, ADDR_CTRL, 32'h3, d);
        chk("rw_same_cycle", d, 32'h1);
        rd_at(cyc + 2, ADDR_CTRL, d);
        chk("rw_after", d, 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
